// File: rtl/fib_req_arb.sv
// FIB request concentrator: arbitrates N port parse requests onto one FIB
// lookup channel and routes each in-order lookup result back to the port
// that issued it, using a tag FIFO of requesting port indices.
module fib_req_arb #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_SZ   = 64,
  parameter int unsigned RES_SZ    = 4,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned MODE      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           p2f_srdy,
  output logic [NUM_PORTS-1:0]           p2f_drdy,
  input  logic [NUM_PORTS*DATA_SZ-1:0]   p2f_data,
  output logic                           ppi_srdy,
  input  logic                           ppi_drdy,
  output logic [DATA_SZ-1:0]             ppi_data,
  output logic [$clog2(NUM_PORTS)-1:0]   ppi_port,
  input  logic                           fres_srdy,
  output logic                           fres_drdy,
  input  logic [RES_SZ-1:0]              fres_data,
  output logic [NUM_PORTS-1:0]           flo_srdy,
  input  logic [NUM_PORTS-1:0]           flo_drdy,
  output logic [RES_SZ-1:0]              flo_data,
  output logic [$clog2(MAX_OUT):0]       outstanding,
  output logic                           err_orphan
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned TW = $clog2(MAX_OUT);
  localparam int unsigned CW = TW + 1;

  // Request stage state
  logic               r_ppi_srdy;
  logic [DATA_SZ-1:0] r_ppi_data;
  logic [PW-1:0]      r_ppi_port;
  logic [PW-1:0]      r_rr_ptr;

  // Tag FIFO and outstanding count (the count doubles as FIFO occupancy)
  logic [PW-1:0]      r_tag_mem [MAX_OUT];
  logic [TW-1:0]      r_wr_ptr;
  logic [TW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_out_cnt;

  // Response stage state
  logic               r_flo_valid;
  logic [PW-1:0]      r_flo_port;
  logic [RES_SZ-1:0]  r_flo_data;
  logic               r_err_orphan;

  // Arbitration and handshake wires
  int unsigned        w_base;
  int unsigned        w_cand;
  logic [PW-1:0]      w_cand_idx;
  logic               w_gnt_found;
  logic [PW-1:0]      w_gnt_idx;
  logic [DATA_SZ-1:0] w_gnt_data;
  logic [PW-1:0]      w_ptr_nxt;
  logic               w_grant_ok;
  logic               w_grant;
  logic               w_empty;
  logic               w_flo_port_drdy;
  logic               w_fres_hs;
  logic               w_pop;
  logic               w_orphan;
  logic               w_flo_hs;

  // Search start: rotating pointer in round-robin, port 0 in fixed priority
  assign w_base = (MODE == 1) ? 0 : 32'(r_rr_ptr);

  // First requester found walking upward from the search start, with wrap
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = 0;
    w_cand_idx  = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      w_cand = w_base + off;
      if (w_cand >= NUM_PORTS) begin
        w_cand = w_cand - NUM_PORTS;
      end
      w_cand_idx = PW'(w_cand);
      if (!w_gnt_found && p2f_srdy[w_cand_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand_idx;
      end
    end
  end

  // Winner's request payload
  always_comb begin
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_gnt_idx == PW'(i)) begin
        w_gnt_data = p2f_data[i*DATA_SZ +: DATA_SZ];
      end
    end
  end

  assign w_ptr_nxt  = (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);

  // Grant only when the output register frees up and a tag slot is available
  assign w_grant_ok = (~r_ppi_srdy | ppi_drdy) & (r_out_cnt < CW'(MAX_OUT));
  assign w_grant    = w_grant_ok & w_gnt_found;

  // One-hot accept on the winner
  always_comb begin
    p2f_drdy = '0;
    if (w_grant) begin
      p2f_drdy[w_gnt_idx] = 1'b1;
    end
  end

  // Response side handshakes; orphan results are always accepted and dropped
  assign w_empty         = (r_out_cnt == '0);
  assign w_flo_port_drdy = flo_drdy[r_flo_port];
  assign fres_drdy       = w_empty | ~r_flo_valid | w_flo_port_drdy;
  assign w_fres_hs       = fres_srdy & fres_drdy;
  assign w_pop           = w_fres_hs & ~w_empty;
  assign w_orphan        = w_fres_hs & w_empty;
  assign w_flo_hs        = r_flo_valid & w_flo_port_drdy;

  // Request output register and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ppi_srdy <= 1'b0;
      r_ppi_data <= '0;
      r_ppi_port <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_ppi_srdy <= 1'b1;
        r_ppi_data <= w_gnt_data;
        r_ppi_port <= w_gnt_idx;
        if (MODE == 0) begin
          r_rr_ptr <= w_ptr_nxt;
        end
      end else if (ppi_drdy) begin
        r_ppi_srdy <= 1'b0;
      end
    end
  end

  // Tag storage: no reset needed, occupancy lives in the pointers and count
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

  // Tag FIFO pointers and outstanding count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_wr_ptr <= r_wr_ptr + TW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TW'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Result output register, steered by the head tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flo_valid <= 1'b0;
      r_flo_port  <= '0;
      r_flo_data  <= '0;
    end else begin
      if (w_pop) begin
        r_flo_valid <= 1'b1;
        r_flo_port  <= r_tag_mem[r_rd_ptr];
        r_flo_data  <= fres_data;
      end else if (w_flo_hs) begin
        r_flo_valid <= 1'b0;
      end
    end
  end

  // Sticky orphan-result flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_orphan <= 1'b0;
    end else if (w_orphan) begin
      r_err_orphan <= 1'b1;
    end
  end

  // Per-port result valid decode
  always_comb begin
    flo_srdy = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      flo_srdy[i] = r_flo_valid & (r_flo_port == PW'(i));
    end
  end

  assign ppi_srdy    = r_ppi_srdy;
  assign ppi_data    = r_ppi_data;
  assign ppi_port    = r_ppi_port;
  assign flo_data    = r_flo_data;
  assign outstanding = r_out_cnt;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_fib_req_arb.sv
// Bench for fib_req_arb: randomized and directed traffic checked every cycle
// against a queue-based model, plus literal expectations from the test plan.
module tb_fib_req_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned RW = 4;
  localparam int unsigned MO = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Round-robin DUT signals
  logic [N-1:0]    p2f_srdy, p2f_drdy;
  logic [N*DW-1:0] p2f_data;
  logic            ppi_srdy, ppi_drdy;
  logic [DW-1:0]   ppi_data;
  logic [PW-1:0]   ppi_port;
  logic            fres_srdy, fres_drdy;
  logic [RW-1:0]   fres_data;
  logic [N-1:0]    flo_srdy, flo_drdy;
  logic [RW-1:0]   flo_data;
  logic [CW-1:0]   outstanding;
  logic            err_orphan;

  // Fixed-priority DUT signals
  logic [N-1:0]    fp_srdy, fp_drdy, fp_flo_srdy;
  logic [N*DW-1:0] fp_data;
  logic            fp_ppi_srdy, fp_fres_drdy, fp_err;
  logic [DW-1:0]   fp_ppi_data;
  logic [PW-1:0]   fp_ppi_port;
  logic [RW-1:0]   fp_flo_data;
  logic [CW-1:0]   fp_outstanding;

  fib_req_arb #(.NUM_PORTS(N), .DATA_SZ(DW), .RES_SZ(RW), .MAX_OUT(MO), .MODE(0)) u_dut (
    .clk(clk), .reset(rst_n),
    .p2f_srdy(p2f_srdy), .p2f_drdy(p2f_drdy), .p2f_data(p2f_data),
    .ppi_srdy(ppi_srdy), .ppi_drdy(ppi_drdy), .ppi_data(ppi_data), .ppi_port(ppi_port),
    .fres_srdy(fres_srdy), .fres_drdy(fres_drdy), .fres_data(fres_data),
    .flo_srdy(flo_srdy), .flo_drdy(flo_drdy), .flo_data(flo_data),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  fib_req_arb #(.NUM_PORTS(N), .DATA_SZ(DW), .RES_SZ(RW), .MAX_OUT(MO), .MODE(1)) u_dut_fp (
    .clk(clk), .reset(rst_n),
    .p2f_srdy(fp_srdy), .p2f_drdy(fp_drdy), .p2f_data(fp_data),
    .ppi_srdy(fp_ppi_srdy), .ppi_drdy(1'b1), .ppi_data(fp_ppi_data), .ppi_port(fp_ppi_port),
    .fres_srdy(1'b1), .fres_drdy(fp_fres_drdy), .fres_data(4'h0),
    .flo_srdy(fp_flo_srdy), .flo_drdy(4'hF), .flo_data(fp_flo_data),
    .outstanding(fp_outstanding), .err_orphan(fp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit            m_ppi_valid;
  int            m_ppi_port;
  logic [DW-1:0] m_ppi_data;
  int            m_ptr;
  int            tags[$];
  bit            m_flo_valid;
  int            m_flo_port;
  logic [RW-1:0] m_flo_data;
  bit            m_err;
  logic [RW-1:0] fib_q[$];
  logic [RW-1:0] res_vals[$];

  // Stimulus knobs
  bit            k_srdy_rand;
  logic [N-1:0]  k_srdy;
  int            k_ppi_pct, k_fres_pct, k_flo_pct;
  logic [N-1:0]  k_flo_mask;
  int            k_budget;
  bit            k_orphan;

  // Observation logs
  int            grant_log[$];
  logic [N-1:0]  flo_log_p[$];
  logic [RW-1:0] flo_log_d[$];
  int            max_out_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int exp_grant(input logic [N-1:0] srdy);
    if (m_ppi_valid && !ppi_drdy) return -1;
    if (tags.size() >= int'(MO)) return -1;
    for (int off = 0; off < int'(N); off++) begin
      int k;
      k = (m_ptr + off) % int'(N);
      if (srdy[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_ppi_valid = 0; m_ptr = 0; m_flo_valid = 0; m_err = 0;
    m_ppi_port = 0; m_flo_port = 0; m_ppi_data = '0; m_flo_data = '0;
    tags.delete(); fib_q.delete(); res_vals.delete();
    grant_log.delete(); flo_log_p.delete(); flo_log_d.delete();
    max_out_seen = 0;
  endtask

  task automatic idle_inputs();
    p2f_srdy = '0; p2f_data = '0; ppi_drdy = 1'b0;
    fres_srdy = 1'b0; fres_data = '0; flo_drdy = '0;
    fp_srdy = '0; fp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive, check all outputs against the model, then advance it
  task automatic cycle();
    int            g;
    bit            exp_fres_drdy, ppi_hs, fres_hs, flo_hs;
    logic [N-1:0]  exp_drdy, exp_flo;
    @(negedge clk);
    p2f_srdy = k_srdy_rand ? N'($urandom) : k_srdy;
    for (int i = 0; i < int'(N); i++) p2f_data[i*DW +: DW] = {$urandom, $urandom};
    ppi_drdy = int'($urandom_range(99, 0)) < k_ppi_pct;
    if (k_orphan) begin
      fres_srdy = 1'b1; fres_data = 4'h3; k_orphan = 0;
    end else if (fib_q.size() > 0 && k_budget > 0 && int'($urandom_range(99, 0)) < k_fres_pct) begin
      fres_srdy = 1'b1; fres_data = fib_q[0];
    end else begin
      fres_srdy = 1'b0; fres_data = RW'($urandom);
    end
    for (int i = 0; i < int'(N); i++)
      flo_drdy[i] = k_flo_mask[i] && (int'($urandom_range(99, 0)) < k_flo_pct);
    #1;
    g             = exp_grant(p2f_srdy);
    exp_drdy      = (g >= 0) ? (N'(1) << g) : '0;
    exp_fres_drdy = (tags.size() == 0) || !m_flo_valid || flo_drdy[m_flo_port];
    exp_flo       = m_flo_valid ? (N'(1) << m_flo_port) : '0;
    chk("p2f_drdy", 64'(p2f_drdy), 64'(exp_drdy));
    chk("fres_drdy", 64'(fres_drdy), 64'(exp_fres_drdy));
    chk("ppi_srdy", 64'(ppi_srdy), 64'(m_ppi_valid));
    if (m_ppi_valid) begin
      chk("ppi_port", 64'(ppi_port), 64'(m_ppi_port));
      chk("ppi_data", 64'(ppi_data), 64'(m_ppi_data));
    end
    chk("flo_srdy", 64'(flo_srdy), 64'(exp_flo));
    if (m_flo_valid) chk("flo_data", 64'(flo_data), 64'(m_flo_data));
    chk("outstanding", 64'(outstanding), 64'(tags.size()));
    chk("err_orphan", 64'(err_orphan), 64'(m_err));
    for (int i = 0; i < int'(N); i++) if (p2f_drdy[i] && p2f_srdy[i]) grant_log.push_back(i);
    if (|(flo_srdy & flo_drdy)) begin
      flo_log_p.push_back(flo_srdy);
      flo_log_d.push_back(flo_data);
    end
    if (int'(outstanding) > max_out_seen) max_out_seen = int'(outstanding);
    @(posedge clk);
    ppi_hs  = m_ppi_valid && ppi_drdy;
    fres_hs = fres_srdy && exp_fres_drdy;
    flo_hs  = m_flo_valid && flo_drdy[m_flo_port];
    if (fres_hs) begin
      if (tags.size() > 0) begin
        m_flo_valid = 1;
        m_flo_port  = tags.pop_front();
        m_flo_data  = fres_data;
        if (fib_q.size() > 0) void'(fib_q.pop_front());
        if (k_budget > 0) k_budget--;
      end else begin
        m_err = 1;
      end
    end else if (flo_hs) begin
      m_flo_valid = 0;
    end
    if (ppi_hs) begin
      if (res_vals.size() > 0) fib_q.push_back(res_vals.pop_front());
      else fib_q.push_back(RW'($urandom));
    end
    if (g >= 0) begin
      tags.push_back(g);
      m_ppi_valid = 1;
      m_ppi_port  = g;
      m_ppi_data  = p2f_data[g*DW +: DW];
      m_ptr       = (g + 1) % int'(N);
    end else if (ppi_drdy) begin
      m_ppi_valid = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
    #2;
  endtask

  task automatic set_knobs(input bit srand, input logic [N-1:0] srdy, input int pp,
                           input int fp, input int flp, input logic [N-1:0] mask, input int bud);
    k_srdy_rand = srand; k_srdy = srdy; k_ppi_pct = pp; k_fres_pct = fp;
    k_flo_pct = flp; k_flo_mask = mask; k_budget = bud; k_orphan = 0;
  endtask

  initial begin
    k_orphan = 0;
    do_reset();
    #1;
    chk("rst_ppi_srdy", 64'(ppi_srdy), 64'd0);
    chk("rst_flo_srdy", 64'(flo_srdy), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);

    // Fixed priority: ports 1 and 3 request, only 1 wins until it drops
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); fp_srdy = 4'b1010; #1;
      chk("fp_grant_p1", 64'(fp_drdy), 64'h2);
    end
    @(negedge clk); fp_srdy = 4'b1000; #1;
    chk("fp_grant_p3", 64'(fp_drdy), 64'h8);
    @(posedge clk); #2;
    chk("fp_ppi_port", 64'(fp_ppi_port), 64'd3);
    @(negedge clk); fp_srdy = '0;

    // Round-robin rotation with prompt returns
    do_reset();
    set_knobs(0, 4'b1111, 100, 100, 100, 4'b1111, 100000);
    run(12);
    chk("rr_grant_count", 64'(grant_log.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("rr_grant_seq", 64'(grant_log[i]), 64'(i % 4));
    for (int i = 0; i < 4 && i < flo_log_p.size(); i++)
      chk("rr_flo_seq", 64'(flo_log_p[i]), 64'(4'b0001 << i));
    chk("rr_max_outstanding", 64'(max_out_seen <= 2), 64'd1);

    // Outstanding limit
    do_reset();
    set_knobs(0, 4'b1111, 100, 100, 100, 4'b1111, 0);
    run(8);
    chk("lim_outstanding", 64'(outstanding), 64'd4);
    chk("lim_drdy_zero", 64'(p2f_drdy), 64'd0);
    chk("lim_grants", 64'(grant_log.size()), 64'd4);
    k_budget = 1;
    run(1);
    chk("lim_after_return", 64'(outstanding), 64'd3);
    chk("lim_no_grant_same_cycle", 64'(grant_log.size()), 64'd4);
    run(1);
    chk("lim_fifth_grant", 64'(grant_log.size()), 64'd5);
    chk("lim_full_again", 64'(outstanding), 64'd4);

    // Routing under backpressure: ports 2,0,1 with results A,5,C
    do_reset();
    set_knobs(0, 4'b0100, 100, 100, 100, 4'b1011, 100000);
    res_vals.push_back(4'hA); res_vals.push_back(4'h5); res_vals.push_back(4'hC);
    run(1);
    k_srdy = 4'b0001; run(1);
    k_srdy = 4'b0010; run(1);
    k_srdy = 4'b0000; run(5);
    chk("bp_flo_srdy", 64'(flo_srdy), 64'h4);
    chk("bp_flo_data", 64'(flo_data), 64'hA);
    chk("bp_fres_drdy", 64'(fres_drdy), 64'd0);
    k_flo_mask = 4'b1111;
    run(6);
    chk("bp_flo_count", 64'(flo_log_p.size()), 64'd3);
    if (flo_log_p.size() == 3) begin
      chk("bp_flo0_port", 64'(flo_log_p[0]), 64'h4);
      chk("bp_flo0_data", 64'(flo_log_d[0]), 64'hA);
      chk("bp_flo1_port", 64'(flo_log_p[1]), 64'h1);
      chk("bp_flo1_data", 64'(flo_log_d[1]), 64'h5);
      chk("bp_flo2_port", 64'(flo_log_p[2]), 64'h2);
      chk("bp_flo2_data", 64'(flo_log_d[2]), 64'hC);
    end

    // Orphan result, then normal traffic
    do_reset();
    set_knobs(0, 4'b0000, 100, 100, 100, 4'b1111, 100000);
    k_orphan = 1;
    run(1);
    chk("orph_err", 64'(err_orphan), 64'd1);
    chk("orph_flo_srdy", 64'(flo_srdy), 64'd0);
    chk("orph_outstanding", 64'(outstanding), 64'd0);
    set_knobs(1, 4'b0000, 70, 60, 70, 4'b1111, 100000);
    run(200);
    chk("orph_err_held", 64'(err_orphan), 64'd1);
    chk("orph_traffic", 64'(flo_log_p.size() > 0), 64'd1);

    // Reset mid-operation
    do_reset();
    set_knobs(0, 4'b0010, 100, 100, 100, 4'b0000, 1);
    run(1);
    k_srdy = 4'b1111; run(3);
    chk("mid_outstanding", 64'(outstanding), 64'd3);
    chk("mid_ppi_srdy", 64'(ppi_srdy), 64'd1);
    chk("mid_flo_srdy", 64'(flo_srdy), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("async_flo_srdy", 64'(flo_srdy), 64'd0);
    chk("async_ppi_srdy", 64'(ppi_srdy), 64'd0);
    chk("async_outstanding", 64'(outstanding), 64'd0);
    do_reset();
    set_knobs(0, 4'b1111, 100, 100, 100, 4'b1111, 100000);
    run(3);
    if (grant_log.size() > 0) chk("post_rst_first_grant", 64'(grant_log[0]), 64'd0);
    else chk("post_rst_first_grant", 64'hFFFF, 64'd0);

    // Randomized traffic at two load points
    do_reset();
    set_knobs(1, 4'b0000, 70, 60, 70, 4'b1111, 100000);
    run(2000);
    k_ppi_pct = 30; k_fres_pct = 40; k_flo_pct = 40;
    run(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_req_arb.md
Name: fib_req_arb

Overview:
- Parametrised FIB request concentrator for the N-port bridge; replaces the fixed 4-port round-robin arbiter plus broadcast-result scheme.
- Arbitrates N port-macro parse requests onto one FIB lookup request channel.
- Records the requesting port of every request in an in-order tag FIFO and routes each lookup result back to that port only, with per-port srdy/drdy.
- Supports round-robin or fixed-priority arbitration and a bounded number of outstanding lookups.

Parameters:
- NUM_PORTS, 4: number of port macros; 2..16.
- DATA_SZ, 64: parse request width (PAR_DATA_SZ).
- RES_SZ, 4: lookup result width (forwarding mask, normally NUM_PORTS).
- MAX_OUT, 4: maximum outstanding lookups (tag FIFO depth); power of 2, 2..16.
- MODE, 0: 0 = round-robin; 1 = fixed priority (lowest port index wins).

Ports:
- clk  in  1  bridge core clock
- reset  in  1  asynchronous, active-low reset
- p2f_srdy  in  NUM_PORTS  per-port request valid
- p2f_drdy  out  NUM_PORTS  per-port request accept
- p2f_data  in  NUM_PORTS*DATA_SZ  requests; port i occupies bits [i*DATA_SZ +: DATA_SZ]
- ppi_srdy  out  1  request to FIB lookup valid
- ppi_drdy  in  1  FIB lookup accepts request
- ppi_data  out  DATA_SZ  request data
- ppi_port  out  clog2(NUM_PORTS)  source port of ppi_data
- fres_srdy  in  1  lookup result valid
- fres_drdy  out  1  result accepted
- fres_data  in  RES_SZ  lookup result
- flo_srdy  out  NUM_PORTS  per-port result valid, at most one bit set
- flo_drdy  in  NUM_PORTS  per-port result accept
- flo_data  out  RES_SZ  result data, shared by all ports
- outstanding  out  clog2(MAX_OUT)+1  lookups granted but not yet returned
- err_orphan  out  1  sticky: a result arrived with no outstanding tag

Behaviour:
- Reset (reset=0, asynchronous):
  - ppi_srdy, flo_srdy, outstanding and err_orphan go to 0.
  - Round-robin pointer goes to 0; tag FIFO is emptied.
  - ppi_data, ppi_port and flo_data are don't-care.
- Request stage, one output register:
  - grant_ok = (~ppi_srdy | ppi_drdy) & (outstanding < MAX_OUT).
  - When grant_ok is true, the arbiter selects among asserted p2f_srdy.
  - p2f_drdy is one-hot on the winner, or all 0 when grant_ok is false or there is no requester.
  - Each p2f_drdy bit depends combinationally on srdy, on state, and on ppi_drdy.
  - On grant:
    - ppi_data and ppi_port load the winner's data and index on the next edge; ppi_srdy=1.
    - The winner's index is pushed into the tag FIFO.
  - Request latency: 1 clock from p2f handshake to ppi_srdy.
  - Back-to-back grants are allowed: full throughput while ppi_drdy=1.
- Arbitration:
  - MODE 0: search starts at the pointer and wraps modulo NUM_PORTS; after a grant to port k, pointer = (k+1) mod NUM_PORTS. A port requesting continuously waits at most NUM_PORTS-1 grants.
  - MODE 1: lowest asserted index wins; the pointer is unused.
- Outstanding count:
  - Increments on grant; decrements on fres handshake (fres_srdy & fres_drdy).
  - Grant and return in the same cycle leave the count unchanged.
  - At outstanding == MAX_OUT no grant is issued, even if a return happens in that same cycle; the count is checked as registered.
- Response stage, one register:
  - fres_drdy = ~flo_valid | flo_drdy[flo_port].
  - On fres handshake with the tag FIFO non-empty:
    - Pop the head tag.
    - flo_data <= fres_data; flo_port <= head tag.
    - flo_srdy becomes one-hot at the tag on the next edge.
  - flo_srdy[i] = flo_valid & (flo_port == i).
  - flo_valid clears on a flo handshake unless a new result loads in the same cycle.
  - Result latency: 1 clock.
  - Results return strictly in request order; the FIB lookup must be in-order.
- Orphan result (fres_srdy=1 with the tag FIFO empty):
  - fres_drdy=1 and the result is dropped; no flo_srdy.
  - err_orphan is set and stays set until reset. outstanding stays 0.
- Simultaneous push and pop of the tag FIFO are both performed; FIFO pointers wrap modulo MAX_OUT.
- Data stability: ppi_data/ppi_port and flo_data/flo_port hold while the corresponding srdy=1 and drdy=0.

Test Plan:
- Round-robin rotation: MODE=0, NUM_PORTS=4, all p2f_srdy=1, ppi_drdy=1, fres returned 2 cycles after each ppi handshake -> ppi_port sequence 0,1,2,3,0,...; flo_srdy one-hot follows the same sequence; outstanding never exceeds 2.
- Fixed priority: MODE=1, ports 1 and 3 requesting continuously -> only port 1 is granted; port 3 is granted on the first cycle port 1 drops srdy.
- Outstanding limit: MAX_OUT=4, fres_srdy=0, all ports requesting -> exactly 4 grants, then p2f_drdy=0 and outstanding=4. One result returned -> outstanding=3; a 5th grant is issued on the following cycle.
- Routing under backpressure: requests from ports 2,0,1 in that order, results 0xA,0x5,0xC, flo_drdy[2]=0 for 5 cycles -> flo_srdy=0100 with flo_data=0xA held stable; fres_drdy=0 while held; then 0001/0x5, then 0010/0xC.
- Orphan: empty FIFO, fres_srdy=1 with 0x3 -> fres_drdy=1, no flo_srdy, err_orphan=1 and held; normal traffic afterwards is unaffected.
- Reset mid-operation: assert reset with 3 outstanding and flo_srdy=1 -> flo_srdy, ppi_srdy and outstanding are 0 immediately without waiting for a clock. After release, the first grant goes to port 0 (pointer reset).
